// File: rtl/alu_cond_writeback_if.sv
// Bundle between the ALU stage, the conditional-writeback stage and the register-file port.
// master drives the instruction and consumes the writeback; slave is the writeback stage.
interface alu_cond_writeback_if #(
  parameter int N     = 4,
  parameter int RD_W  = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     ALUResult;
  logic [3:0]       ALUFlags;
  logic [3:0]       Cond;
  logic [1:0]       FlagWrite;
  logic             RegWrite;
  logic [RD_W-1:0]  Rd;
  logic             out_valid;
  logic             out_ready;
  logic             wb_en;
  logic [RD_W-1:0]  wb_addr;
  logic [N-1:0]     wb_data;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cond_fail_cnt;

  modport master (
    output in_valid, ALUResult, ALUFlags, Cond, FlagWrite, RegWrite, Rd, out_ready,
    input  in_ready, out_valid, wb_en, wb_addr, wb_data, flags_q, cond_fail_cnt
  );

  modport slave (
    input  in_valid, ALUResult, ALUFlags, Cond, FlagWrite, RegWrite, Rd, out_ready,
    output in_ready, out_valid, wb_en, wb_addr, wb_data, flags_q, cond_fail_cnt
  );
endinterface

// File: rtl/alu_cond_writeback.sv
// Condition-code evaluation, architectural NZCV flags and a one-deep registered
// writeback slot with valid/ready handshake, sitting directly behind the ALU.
module alu_cond_writeback #(
  parameter int N     = 4,
  parameter int RD_W  = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  alu_cond_writeback_if.slave bus
);

  // Flag bit positions shared by ALUFlags and flags_q.
  localparam int F_N = 0;
  localparam int F_C = 1;
  localparam int F_Z = 2;
  localparam int F_V = 3;

  logic             vld_p1;
  logic             wb_en_p1;
  logic [RD_W-1:0]  wb_addr_p1;
  logic [N-1:0]     wb_data_p1;
  logic [3:0]       flags_p1;
  logic [CNT_W-1:0] fail_cnt_p1;

  logic in_ready;
  logic accept;
  logic cond_pass;

  function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] fl);
    logic n, z, c, v;
    n = fl[F_N];
    z = fl[F_Z];
    c = fl[F_C];
    v = fl[F_V];
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c && !z;
      4'b1001: cond_ex = !c || z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

  // FlagWrite[1] governs the N/Z pair, FlagWrite[0] the C/V pair.
  function automatic logic [3:0] merge_flags(input logic [3:0] cur, input logic [3:0] alu,
                                             input logic [1:0] fw);
    logic [3:0] nxt;
    nxt = cur;
    if (fw[1]) begin
      nxt[F_N] = alu[F_N];
      nxt[F_Z] = alu[F_Z];
    end
    if (fw[0]) begin
      nxt[F_C] = alu[F_C];
      nxt[F_V] = alu[F_V];
    end
    merge_flags = nxt;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) sat_inc = cnt;
    else                      sat_inc = cnt + 1'b1;
  endfunction

  // Stage p0: combinational accept decision against the current architectural flags.
  assign in_ready  = !vld_p1 || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign cond_pass = cond_ex(bus.Cond, flags_p1);

  // Stage p1: writeback slot, flags and fail counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      wb_en_p1    <= 1'b0;
      wb_addr_p1  <= '0;
      wb_data_p1  <= '0;
      flags_p1    <= 4'b0000;
      fail_cnt_p1 <= '0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      wb_en_p1   <= bus.RegWrite && cond_pass;
      wb_addr_p1 <= bus.Rd;
      wb_data_p1 <= bus.ALUResult;
      if (cond_pass) flags_p1    <= merge_flags(flags_p1, bus.ALUFlags, bus.FlagWrite);
      else           fail_cnt_p1 <= sat_inc(fail_cnt_p1);
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1   <= 1'b0;
      wb_en_p1 <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = vld_p1;
  assign bus.wb_en         = wb_en_p1;
  assign bus.wb_addr       = wb_addr_p1;
  assign bus.wb_data       = wb_data_p1;
  assign bus.flags_q       = flags_p1;
  assign bus.cond_fail_cnt = fail_cnt_p1;

endmodule

// File: tb/tb_alu_cond_writeback.sv
// Directed bench for alu_cond_writeback: condition codes, flag updates, handshake,
// counter saturation and asynchronous reset.
module tb_alu_cond_writeback;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_cond_writeback_if #(.N(4), .RD_W(4), .CNT_W(8)) bus ();

  alu_cond_writeback #(.N(4), .RD_W(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] aflags,
                       input logic rw, input logic [3:0] rd, input logic [3:0] res);
    bus.in_valid  = 1'b1;
    bus.Cond      = cond;
    bus.FlagWrite = fw;
    bus.ALUFlags  = aflags;
    bus.RegWrite  = rw;
    bus.Rd        = rd;
    bus.ALUResult = res;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.Cond      = 4'h0;
    bus.FlagWrite = 2'b00;
    bus.ALUFlags  = 4'h0;
    bus.RegWrite  = 1'b0;
    bus.Rd        = 4'h0;
    bus.ALUResult = 4'h0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
    chk("rst_flags", 32'(bus.flags_q), 32'd0);
    chk("rst_cnt", 32'(bus.cond_fail_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;

    // First instruction: AL, writes N flag
    issue(4'b1110, 2'b11, 4'b0001, 1'b1, 4'd3, 4'hA);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_wb_en", 32'(bus.wb_en), 32'd1);
    chk("t1_wb_addr", 32'(bus.wb_addr), 32'd3);
    chk("t1_wb_data", 32'(bus.wb_data), 32'hA);
    chk("t1_flags", 32'(bus.flags_q), 32'b0001);
    tick();
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_wb_en", 32'(bus.wb_en), 32'd0);
    chk("drain_data_hold", 32'(bus.wb_data), 32'hA);

    // Set Z, then NE back-to-back fails, then EQ passes
    issue(4'b1110, 2'b11, 4'b0100, 1'b1, 4'd1, 4'h5);
    tick();
    chk("z_flags", 32'(bus.flags_q), 32'b0100);
    issue(4'b0001, 2'b11, 4'b1111, 1'b1, 4'd2, 4'h6);
    tick();
    chk("ne_out_valid", 32'(bus.out_valid), 32'd1);
    chk("ne_wb_en", 32'(bus.wb_en), 32'd0);
    chk("ne_wb_data", 32'(bus.wb_data), 32'h6);
    chk("ne_flags_hold", 32'(bus.flags_q), 32'b0100);
    chk("ne_cnt", 32'(bus.cond_fail_cnt), 32'd1);
    issue(4'b0000, 2'b00, 4'b0000, 1'b1, 4'd7, 4'h7);
    tick();
    chk("eq_wb_en", 32'(bus.wb_en), 32'd1);
    chk("eq_wb_addr", 32'(bus.wb_addr), 32'd7);
    chk("eq_cnt", 32'(bus.cond_fail_cnt), 32'd1);

    // Back-to-back: clear flags, then AL sets Z, next EQ sees it
    issue(4'b1110, 2'b11, 4'b0000, 1'b0, 4'd0, 4'h0);
    tick();
    chk("clr_flags", 32'(bus.flags_q), 32'b0000);
    issue(4'b1110, 2'b11, 4'b0100, 1'b0, 4'd0, 4'h1);
    tick();
    issue(4'b0000, 2'b00, 4'b0000, 1'b1, 4'd8, 4'h2);
    tick();
    chk("b2b_wb_en", 32'(bus.wb_en), 32'd1);
    chk("b2b_wb_data", 32'(bus.wb_data), 32'h2);

    // Partial flag update
    issue(4'b1110, 2'b11, 4'b1111, 1'b0, 4'd0, 4'h0);
    tick();
    chk("all_flags", 32'(bus.flags_q), 32'b1111);
    issue(4'b1110, 2'b10, 4'b0000, 1'b0, 4'd0, 4'h0);
    tick();
    chk("partial_flags", 32'(bus.flags_q), 32'b1010);

    // Flags 1010: C=1, V=1, N=0, Z=0 -> HI passes, GE fails
    issue(4'b1000, 2'b00, 4'b0000, 1'b1, 4'd9, 4'h3);
    tick();
    chk("hi_wb_en", 32'(bus.wb_en), 32'd1);
    chk("hi_cnt", 32'(bus.cond_fail_cnt), 32'd1);
    issue(4'b1010, 2'b11, 4'b0000, 1'b1, 4'd9, 4'h4);
    tick();
    chk("ge_wb_en", 32'(bus.wb_en), 32'd0);
    chk("ge_cnt", 32'(bus.cond_fail_cnt), 32'd2);
    chk("ge_flags_hold", 32'(bus.flags_q), 32'b1010);

    // Backpressure
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    issue(4'b1110, 2'b00, 4'b0000, 1'b1, 4'd4, 4'h9);
    tick();
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_wb_data", 32'(bus.wb_data), 32'h9);
    issue(4'b1110, 2'b11, 4'b0101, 1'b1, 4'd5, 4'hC);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("stall_wb_data", 32'(bus.wb_data), 32'h9);
      chk("stall_wb_addr", 32'(bus.wb_addr), 32'd4);
      chk("stall_flags", 32'(bus.flags_q), 32'b1010);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("swap_out_valid", 32'(bus.out_valid), 32'd1);
    chk("swap_wb_data", 32'(bus.wb_data), 32'hC);
    chk("swap_wb_addr", 32'(bus.wb_addr), 32'd5);
    chk("swap_flags", 32'(bus.flags_q), 32'b0101);

    // Saturation: 300 NV instructions from count 2
    issue(4'b1111, 2'b11, 4'b1010, 1'b1, 4'd6, 4'hE);
    for (int i = 0; i < 300; i++) tick();
    chk("sat_cnt", 32'(bus.cond_fail_cnt), 32'd255);
    chk("sat_wb_en", 32'(bus.wb_en), 32'd0);
    chk("sat_flags", 32'(bus.flags_q), 32'b0101);

    // Asynchronous reset mid-cycle
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("arst_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("arst_wb_data", 32'(bus.wb_data), 32'd0);
    chk("arst_flags", 32'(bus.flags_q), 32'd0);
    chk("arst_cnt", 32'(bus.cond_fail_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
